// File: rtl/sobel_pkg.sv
// sobel_pkg: shared luma, kernel and gradient constants plus arithmetic helpers
package sobel_pkg;
  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;
  localparam int LUMA_SHIFT = 8;
  localparam int K_EDGE = 1;
  localparam int K_MID = 2;
  localparam int MAG_MAX = 255;
  localparam int GRAD_W = 11;
  typedef logic [7:0] pix_t;
  typedef logic signed [GRAD_W-1:0] grad_t;
  typedef logic [GRAD_W:0] sum_t;
  function automatic pix_t luma(input pix_t r, input pix_t g, input pix_t b);
    logic [15:0] s;
    s = 16'(LUMA_R) * {8'b0, r} + 16'(LUMA_G) * {8'b0, g} + 16'(LUMA_B) * {8'b0, b};
    return pix_t'(s >> LUMA_SHIFT);
  endfunction
  function automatic grad_t kern(input pix_t a, input pix_t b, input pix_t c,
                                 input pix_t d, input pix_t e, input pix_t f);
    return grad_t'(K_EDGE * int'(d) + K_MID * int'(e) + K_EDGE * int'(f)
                 - K_EDGE * int'(a) - K_MID * int'(b) - K_EDGE * int'(c));
  endfunction
  function automatic sum_t abs_g(input grad_t g);
    return sum_t'(g[GRAD_W-1] ? -g : g);
  endfunction
endpackage

// File: rtl/sobel_edge_stream_if.sv
// sobel_edge_stream_if: RGB pixel stream in, gradient magnitude/edge stream out; master = source, slave = detector
interface sobel_edge_stream_if #(
  parameter int COORD_BITS = 11
);
  logic in_valid;
  logic [7:0] in_R, in_G, in_B;
  logic [COORD_BITS-1:0] in_x, in_y;
  logic out_valid;
  logic [7:0] out_mag;
  logic out_edge;
  logic [COORD_BITS-1:0] out_x, out_y;
  modport master (
    output in_valid, in_R, in_G, in_B, in_x, in_y,
    input  out_valid, out_mag, out_edge, out_x, out_y
  );
  modport slave (
    input  in_valid, in_R, in_G, in_B, in_x, in_y,
    output out_valid, out_mag, out_edge, out_x, out_y
  );
endinterface

// File: rtl/sobel_line_buffer.sv
// sobel_line_buffer: DEPTH x 8 RAM, registered read, read-before-write; ports clk, we_i/waddr_i/wdata_i, re_i/raddr_i, rdata_o
module sobel_line_buffer #(
  parameter int DEPTH = 768,
  parameter int AW = 11
) (
  input  logic         clk,
  input  logic         we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [7:0]   wdata_i,
  input  logic         re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [7:0]   rdata_o
);
  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;
  always_ff @(posedge clk) begin
    if (re_i) rdata_q <= mem[raddr_i];
    if (we_i) mem[waddr_i] <= wdata_i;
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/sobel_edge_stream.sv
// sobel_edge_stream: streaming 3x3 Sobel edge detector; ports CAMERA_CLK, rst (async active-low), px (RGB in, magnitude/edge out)
module sobel_edge_stream
  import sobel_pkg::*;
#(
  parameter int WIDTH = 768,
  parameter int HEIGHT = 512,
  parameter int COORD_BITS = 11,
  parameter int THRESH = 128
) (
  input logic CAMERA_CLK,
  input logic rst,
  sobel_edge_stream_if.slave px
);
  localparam logic [COORD_BITS-1:0] ONE = COORD_BITS'(1);
  logic sof, acc, synced_q;
  pix_t gray, rd0, rd1, gray_q, mag_d;
  logic v1_q, sh1_q, bd1_q, v2_q, bd2_q;
  logic [COORD_BITS-1:0] wx1_q, cx1_q, cy1_q, cx2_q, cy2_q;
  pix_t win_q [3][3];
  grad_t gx, gy;
  sum_t sum;
  assign sof = px.in_x == '0 && px.in_y == '0;
  // out-of-range coordinates are dropped so they can never address past the RAM
  assign acc = px.in_valid && px.in_x < COORD_BITS'(WIDTH) && px.in_y < COORD_BITS'(HEIGHT)
               && (synced_q || sof);
  assign gray = luma(px.in_R, px.in_G, px.in_B);
  sobel_line_buffer #(.DEPTH(WIDTH), .AW(COORD_BITS)) u_lb1 (
    .clk(CAMERA_CLK), .we_i(acc), .waddr_i(px.in_x), .wdata_i(gray),
    .re_i(acc), .raddr_i(px.in_x), .rdata_o(rd1)
  );
  // lb0 takes the old row y-1 value one cycle later, once the registered lb1 read is available
  sobel_line_buffer #(.DEPTH(WIDTH), .AW(COORD_BITS)) u_lb0 (
    .clk(CAMERA_CLK), .we_i(sh1_q), .waddr_i(wx1_q), .wdata_i(rd1),
    .re_i(acc), .raddr_i(px.in_x), .rdata_o(rd0)
  );
  always_comb begin
    gx = kern(win_q[0][0], win_q[1][0], win_q[2][0], win_q[0][2], win_q[1][2], win_q[2][2]);
    gy = kern(win_q[0][0], win_q[0][1], win_q[0][2], win_q[2][0], win_q[2][1], win_q[2][2]);
    sum = abs_g(gx) + abs_g(gy);
    mag_d = bd2_q ? '0 : sum > sum_t'(MAG_MAX) ? pix_t'(MAG_MAX) : sum[7:0];
  end
  always_ff @(posedge CAMERA_CLK or negedge rst) begin
    if (!rst) begin
      synced_q <= 1'b0;
      v1_q <= 1'b0;
      sh1_q <= 1'b0;
      bd1_q <= 1'b0;
      gray_q <= '0;
      wx1_q <= '0;
      cx1_q <= '0;
      cy1_q <= '0;
      v2_q <= 1'b0;
      bd2_q <= 1'b0;
      cx2_q <= '0;
      cy2_q <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
      px.out_valid <= 1'b0;
      px.out_mag <= '0;
      px.out_edge <= 1'b0;
      px.out_x <= '0;
      px.out_y <= '0;
    end else begin
      synced_q <= synced_q || acc;
      v1_q <= acc && px.in_x != '0 && px.in_y != '0;
      sh1_q <= acc;
      if (acc) begin
        gray_q <= gray;
        wx1_q <= px.in_x;
        cx1_q <= px.in_x - ONE;
        cy1_q <= px.in_y - ONE;
        bd1_q <= px.in_x == ONE || px.in_y == ONE;
      end
      v2_q <= v1_q;
      if (sh1_q) begin
        for (int r = 0; r < 3; r++) begin
          win_q[r][0] <= win_q[r][1];
          win_q[r][1] <= win_q[r][2];
        end
        win_q[0][2] <= rd0;
        win_q[1][2] <= rd1;
        win_q[2][2] <= gray_q;
        cx2_q <= cx1_q;
        cy2_q <= cy1_q;
        bd2_q <= bd1_q;
      end
      px.out_valid <= v2_q;
      if (v2_q) begin
        px.out_mag <= mag_d;
        px.out_edge <= mag_d >= pix_t'(THRESH);
        px.out_x <= cx2_q;
        px.out_y <= cy2_q;
      end
    end
  end
endmodule

// File: tb/tb_sobel_edge_stream.sv
// tb_sobel_edge_stream: scoreboard bench for sobel_edge_stream on an 8x6 frame
module tb_sobel_edge_stream;
  localparam int W = 8;
  localparam int H = 6;
  localparam int CB = 11;
  typedef struct {
    int t;
    int x;
    int y;
    int mag;
    int edg;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int cyc = 0;
  int checks = 0;
  int errors = 0;
  int n_out = 0;
  bit exp_on = 1'b0;
  exp_t sb[$];
  exp_t e;
  int rr[H][W], gg[H][W], bb[H][W], gimg[H][W];
  sobel_edge_stream_if #(.COORD_BITS(CB)) bus();
  sobel_edge_stream #(.WIDTH(W), .HEIGHT(H), .COORD_BITS(CB), .THRESH(128)) dut (
    .CAMERA_CLK(clk), .rst(rst_n), .px(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input int got, input int exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp_v, cyc);
    end
  endtask
  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"}, int'(bus.out_valid), 0);
    chk({tag, "_mag"}, int'(bus.out_mag), 0);
    chk({tag, "_edge"}, int'(bus.out_edge), 0);
    chk({tag, "_x"}, int'(bus.out_x), 0);
    chk({tag, "_y"}, int'(bus.out_y), 0);
  endtask
  task automatic fill(input int mode);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int v;
        v = 0;
        rr[y][x] = 0;
        gg[y][x] = 0;
        bb[y][x] = 0;
        case (mode)
          0: v = 100;
          1: v = x < 4 ? 0 : 255;
          2: v = y < 3 ? 0 : 60;
          default: v = 0;
        endcase
        if (mode <= 2) begin
          rr[y][x] = v;
          gg[y][x] = v;
          bb[y][x] = v;
        end
        if (mode == 3 && x == 4 && y == 3) rr[y][x] = 255;
        if (mode == 4 && x == 4 && y == 3) bb[y][x] = 255;
        if (mode == 5) begin
          rr[y][x] = int'($urandom_range(255));
          gg[y][x] = int'($urandom_range(255));
          bb[y][x] = int'($urandom_range(255));
        end
        gimg[y][x] = (77 * rr[y][x] + 150 * gg[y][x] + 29 * bb[y][x]) >> 8;
      end
  endtask
  function automatic int gold(input int cx, input int cy);
    int gx, gy, s;
    if (cx == 0 || cy == 0) return 0;
    gx = (gimg[cy-1][cx+1] + 2 * gimg[cy][cx+1] + gimg[cy+1][cx+1])
       - (gimg[cy-1][cx-1] + 2 * gimg[cy][cx-1] + gimg[cy+1][cx-1]);
    gy = (gimg[cy+1][cx-1] + 2 * gimg[cy+1][cx] + gimg[cy+1][cx+1])
       - (gimg[cy-1][cx-1] + 2 * gimg[cy-1][cx] + gimg[cy-1][cx+1]);
    s = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return s > 255 ? 255 : s;
  endfunction
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero_outputs("async_rst");
    sb.delete();
    exp_on = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic send_frame(input int bub, input int rst_y, input int rst_x);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        int m;
        while (bub > 0 && int'($urandom_range(99)) < bub) begin
          @(negedge clk);
          bus.in_valid = 1'b0;
        end
        if (y == rst_y && x == rst_x) do_reset();
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_R = 8'(rr[y][x]);
        bus.in_G = 8'(gg[y][x]);
        bus.in_B = 8'(bb[y][x]);
        bus.in_x = CB'(x);
        bus.in_y = CB'(y);
        if (x == 0 && y == 0) exp_on = 1'b1;
        if (exp_on && x > 0 && y > 0) begin
          m = gold(x - 1, y - 1);
          sb.push_back('{cyc + 3, x - 1, y - 1, m, int'(m >= 128)});
        end
      end
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("sb_drain", sb.size(), 0);
  endtask
  task automatic run(input int mode, input int bub);
    fill(mode);
    n_out = 0;
    send_frame(bub, -1, -1);
    chk("n_out", n_out, (W - 1) * (H - 1));
  endtask
  always @(negedge clk)
    if (rst_n && bus.out_valid) begin
      n_out++;
      if (sb.size() == 0) chk("unexpected_out", 1, 0);
      else begin
        e = sb.pop_front();
        chk("latency", cyc, e.t);
        chk("out_x", int'(bus.out_x), e.x);
        chk("out_y", int'(bus.out_y), e.y);
        chk("out_mag", int'(bus.out_mag), e.mag);
        chk("out_edge", int'(bus.out_edge), e.edg);
      end
    end
  initial begin
    bus.in_valid = 1'b0;
    bus.in_R = '0;
    bus.in_G = '0;
    bus.in_B = '0;
    bus.in_x = '0;
    bus.in_y = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_zero_outputs("reset");
    rst_n = 1'b1;
    run(0, 0);
    run(1, 0);
    run(2, 0);
    run(3, 0);
    chk("red_gold_3_3", gold(3, 3), 152);
    run(4, 0);
    chk("blue_gold_3_3", gold(3, 3), 56);
    run(1, 50);
    run(5, 30);
    fill(5);
    send_frame(0, 3, 3);
    n_out = 0;
    send_frame(0, -1, -1);
    chk("n_out_after_rst", n_out, (W - 1) * (H - 1));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_edge_stream.md
Name: sobel_edge_stream

Overview:
- Streaming Sobel edge detector directly downstream of the per-pixel RGB image source (camera model or simulation file reader).
- Consumes one raster-order RGB pixel per cycle with its coordinates and converts it to 8-bit luma.
- Holds two previous lines in line buffers, forms a 3x3 window, and emits a saturated gradient magnitude plus a thresholded edge bit for the window centre.
- Output feeds the BMP writer / display path.

Parameters:
- WIDTH, 768, active pixels per line
- HEIGHT, 512, lines per frame
- COORD_BITS, 11, width of coordinate ports
- THRESH, 128, magnitude at or above which out_edge is set

Ports:
- CAMERA_CLK  in  1  single clock; all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  pixel present this cycle; may drop to 0 anywhere (bubbles)
- in_R  in  8  red component
- in_G  in  8  green component
- in_B  in  8  blue component
- in_x  in  COORD_BITS  column 0..WIDTH-1
- in_y  in  COORD_BITS  row 0..HEIGHT-1
- out_valid  out  1  output pixel strobe
- out_mag  out  8  min(|Gx|+|Gy|, 255)
- out_edge  out  1  out_mag >= THRESH
- out_x  out  COORD_BITS  centre column
- out_y  out  COORD_BITS  centre row

Behaviour:
- Reset (rst=0, async):
  - out_valid=0, out_mag=0, out_edge=0, out_x=0, out_y=0.
  - Window registers, pipeline valids and synced flag are cleared.
  - Line-buffer RAM is not cleared.
- Sync:
  - synced is set by an accepted pixel with in_x=0, in_y=0.
  - Pixels arriving while synced=0 are ignored entirely: no RAM writes, no window shift, no output.
  - Reset mid-frame therefore suppresses output until the next frame start.
- Stage 1 (on accepted pixel): gray = (77*R + 150*G + 29*B) >> 8, 16-bit intermediate.
  - R=G=B=v yields gray=v.
- Stage 2, line buffers: two WIDTH x 8 RAMs, read and written at address in_x.
  - lb1 holds row y-1, lb0 holds row y-2.
  - Each accepted pixel: read lb1[x] and lb0[x]; write lb0[x] <= old lb1[x] and lb1[x] <= gray.
  - Read-before-write at the same address.
  - A column {lb0, lb1, gray} shifts into the 3x3 window, rows top to bottom.
  - Window shift happens only on accepted pixels; bubbles freeze all state.
- Emission:
  - An accepted pixel (x,y) with x>=1 and y>=1 produces exactly one output, centre (x-1, y-1).
  - Pixels with x=0 or y=0 produce no output.
  - The output frame is therefore (WIDTH-1) x (HEIGHT-1): last column and last row are never emitted.
- Border: if centre x=0 or centre y=0, out_mag=0 and out_edge=0.
  - This discards window data that crossed a line or frame boundary.
- Gradient arithmetic: signed 11-bit Gx and Gy.
  - Gx = (p02 + 2*p12 + p22) - (p00 + 2*p10 + p20)
  - Gy = (p20 + 2*p21 + p22) - (p00 + 2*p01 + p02)
  - Sum of absolute values is 12 bits, saturated to 255.
- Latency: out_valid rises exactly 3 cycles after the triggering in_valid cycle.
  - Stages: gray+RAM read, window/gradient, magnitude/register.
  - Pipeline advances every cycle regardless of bubbles; valid bits track each stage.
- Throughput: 1 pixel/clock sustained; no backpressure.
- Coordinates: out_x/out_y travel with the data through the pipeline.
  - A new frame start (0,0) arriving mid-frame re-aligns immediately; no output is produced for it.

Decomposition:
- Shared package sobel_pkg holds:
  - kernel weights;
  - luma coefficients 77/150/29 and shift 8;
  - MAG_MAX = 255;
  - gradient width constant GRAD_W = 11.
- One sub-module: sobel_line_buffer, a parameterised WIDTH x 8 RAM with registered read and read-before-write, instantiated twice.

Test Plan:
- Constant gray 100, WIDTH=8, HEIGHT=6, no bubbles:
  - 35 outputs, each out_mag=0 and out_edge=0.
  - First out_valid 3 cycles after input (1,1), with out=(0,0).
- Vertical step, columns 0-3 gray 0 and 4-7 gray 255:
  - Interior centres at x=3 and x=4 give out_mag=255, out_edge=1.
  - Other interior centres give 0.
  - Border centres give 0.
- Horizontal step, rows 0-2 = 0 and rows 3-5 = 60:
  - Centres at y=2 and y=3 give Gy=240, out_mag=240, out_edge=1.
- Pure red 255, then pure blue 255, single pixel at (4,3) in an otherwise-zero frame:
  - Gray values are 76 and 28 respectively.
  - Centre (4,3) has Gx=0 and Gy=0, so out_mag=0.
  - Centre (3,3) has |Gx|=152 (red) or 56 (blue), so out_mag=152 or 56.
- Random in_valid bubbles (50%) with the step image:
  - Output values and coordinates are identical to the no-bubble run.
  - Each out_valid occurs 3 cycles after its trigger.
- rst pulsed low mid-row 3, then release:
  - Outputs reset to 0 asynchronously.
  - No out_valid until after the next (0,0) input.
  - The following frame's results match the golden model.
